hour: RTL and testbench

HOUR -- requirements
Module: hour

---
 rtl/hour.sv | 141 ++++++++++++++
 tb/tb_hour.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hour.sv
// ---------------------------------------------------------------------------
// hour -- hours stage of a digital clock.
//
// Holds a binary hour count (0..23). In run mode, the count advances when
// the minute stage's carry level falls, which means the minutes have wrapped
// from 59 to 00. In set mode, the count is stepped up or down by edges on the
// debounced buttons. The count is shown as registered BCD digits, in either
// 24 h format or 12 h format with an AM/PM flag.
//
// Parameters
//   INIT_HOUR     : binary hour (0..23) loaded into the count on reset
// Ports
//   hour_clk      : in  1  sole clock, rising edge
//   hour_rst_n    : in  1  synchronous active-low reset
//   hour_carry_in : in  1  level carry from minutes, high while minutes = 59
//   hour_fmt24    : in  1  1 = 24 h display, 0 = 12 h display with AM/PM
//   hour_set      : in  1  1 = manual adjust (carry ignored)
//   hour_up       : in  1  debounced increment button level
//   hour_dn       : in  1  debounced decrement button level
//   hour_tens     : out 2  BCD tens digit of the displayed hour
//   hour_ones     : out 4  BCD ones digit of the displayed hour
//   hour_pm       : out 1  1 when count >= 12 (both formats)
//   hour_day_out  : out 1  one-cycle pulse after a carry-driven 23 -> 0 wrap
// ---------------------------------------------------------------------------
module hour #(
  parameter int unsigned INIT_HOUR = 0
) (
  input  logic       hour_clk,
  input  logic       hour_rst_n,
  input  logic       hour_carry_in,
  input  logic       hour_fmt24,
  input  logic       hour_set,
  input  logic       hour_up,
  input  logic       hour_dn,
  output logic [1:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic       hour_pm,
  output logic       hour_day_out
);

  localparam logic [4:0] LAST_HOUR = 5'd23;
  localparam logic [4:0] INIT_CNT  = INIT_HOUR[4:0];

  // Map the 0..23 count to the hour that is shown on the display.
  // In 12 h mode, midnight and noon both show as 12.
  function automatic logic [4:0] disp_hour(input logic [4:0] cnt,
                                           input logic       fmt24);
    logic [4:0] h;
    h = cnt;
    if (!fmt24) begin
      if (cnt == 5'd0)       h = 5'd12;
      else if (cnt > 5'd12)  h = cnt - 5'd12;
    end
    return h;
  endfunction

  // Binary 0..23 to {tens[1:0], ones[3:0]}.
  function automatic logic [5:0] to_bcd(input logic [4:0] h);
    logic [4:0] r;
    logic [1:0] t;
    if (h >= 5'd20) begin
      t = 2'd2;
      r = h - 5'd20;
    end else if (h >= 5'd10) begin
      t = 2'd1;
      r = h - 5'd10;
    end else begin
      t = 2'd0;
      r = h;
    end
    return {t, r[3:0]};
  endfunction

  logic [4:0] count_q, count_d;
  logic       carry_q;
  logic       up_q, dn_q;
  logic [1:0] tens_q;
  logic [3:0] ones_q;
  logic       pm_q;
  logic       day_q, day_d;

  logic       carry_evt, up_evt, dn_evt;
  logic [4:0] count_inc, count_dec;
  logic [5:0] bcd;

  // A falling carry level marks minutes rolling over to 00. Because the
  // event is tied to the falling edge, a long carry-high period can only
  // produce one increment.
  assign carry_evt = carry_q & ~hour_carry_in;
  assign up_evt    = hour_up & ~up_q;
  assign dn_evt    = hour_dn & ~dn_q;

  assign count_inc = (count_q == LAST_HOUR) ? 5'd0 : count_q + 5'd1;
  assign count_dec = (count_q == 5'd0) ? LAST_HOUR : count_q - 5'd1;

  always_comb begin
    count_d = count_q;
    day_d   = 1'b0;
    if (!hour_set) begin
      if (carry_evt) begin
        count_d = count_inc;
        day_d   = (count_q == LAST_HOUR);
      end
    end else begin
      // Coincident up and down edges cancel each other.
      if (up_evt && !dn_evt)       count_d = count_inc;
      else if (dn_evt && !up_evt)  count_d = count_dec;
    end
    bcd = to_bcd(disp_hour(count_q, hour_fmt24));
  end

  // Button history resets to 1 so that a button held through the release
  // of reset does not look like a fresh press.
  always_ff @(posedge hour_clk) begin
    if (!hour_rst_n) begin
      count_q <= INIT_CNT;
      carry_q <= 1'b0;
      up_q    <= 1'b1;
      dn_q    <= 1'b1;
      tens_q  <= 2'd0;
      ones_q  <= 4'd0;
      pm_q    <= 1'b0;
      day_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= hour_carry_in;
      up_q    <= hour_up;
      dn_q    <= hour_dn;
      tens_q  <= bcd[5:4];
      ones_q  <= bcd[3:0];
      pm_q    <= (count_q >= 5'd12);
      day_q   <= day_d;
    end
  end

  assign hour_tens    = tens_q;
  assign hour_ones    = ones_q;
  assign hour_pm      = pm_q;
  assign hour_day_out = day_q;

endmodule

// File: tb/tb_hour.sv
module tb_hour;

  localparam int INIT = 0;

  logic       hour_clk = 1'b0;
  logic       hour_rst_n;
  logic       hour_carry_in;
  logic       hour_fmt24;
  logic       hour_set;
  logic       hour_up;
  logic       hour_dn;
  logic [1:0] hour_tens;
  logic [3:0] hour_ones;
  logic       hour_pm;
  logic       hour_day_out;

  hour #(.INIT_HOUR(INIT)) dut (
    .hour_clk      (hour_clk),
    .hour_rst_n    (hour_rst_n),
    .hour_carry_in (hour_carry_in),
    .hour_fmt24    (hour_fmt24),
    .hour_set      (hour_set),
    .hour_up       (hour_up),
    .hour_dn       (hour_dn),
    .hour_tens     (hour_tens),
    .hour_ones     (hour_ones),
    .hour_pm       (hour_pm),
    .hour_day_out  (hour_day_out)
  );

  always #5 hour_clk = ~hour_clk;

  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] ones;
    logic       pm;
    logic       day;
  } exp_t;

  exp_t sb[$];

  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int   m_cnt = 0;
  logic m_carry = 1'b0;
  logic m_up = 1'b1;
  logic m_dn = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Predict the outputs after the next edge, advance the model, clock the
  // DUT, then pop the prediction and compare it with the outputs.
  task automatic step();
    exp_t e;
    exp_t g;
    int   h;
    logic ue, de;
    e = '0;
    if (!hour_rst_n) begin
      m_cnt   = INIT;
      m_carry = 1'b0;
      m_up    = 1'b1;
      m_dn    = 1'b1;
    end else begin
      h = m_cnt;
      if (!hour_fmt24) begin
        if (h == 0)       h = 12;
        else if (h > 12)  h = h - 12;
      end
      e.tens = 2'(h / 10);
      e.ones = 4'(h % 10);
      e.pm   = (m_cnt >= 12);
      if (!hour_set) begin
        if (m_carry && !hour_carry_in) begin
          if (m_cnt == 23) begin
            m_cnt = 0;
            e.day = 1'b1;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end else begin
        ue = hour_up && !m_up;
        de = hour_dn && !m_dn;
        if (ue && !de)       m_cnt = (m_cnt + 1) % 24;
        else if (de && !ue)  m_cnt = (m_cnt + 23) % 24;
      end
      m_carry = hour_carry_in;
      m_up    = hour_up;
      m_dn    = hour_dn;
    end
    sb.push_back(e);
    @(posedge hour_clk);
    #1;
    g = sb.pop_front();
    chk("sb_tens", 32'(hour_tens), 32'(g.tens));
    chk("sb_ones", 32'(hour_ones), 32'(g.ones));
    chk("sb_pm",   32'(hour_pm),   32'(g.pm));
    chk("sb_day",  32'(hour_day_out), 32'(g.day));
  endtask

  task automatic disp_is(input string tag, input int t, input int o, input int p);
    chk({tag, "_tens"}, 32'(hour_tens), 32'(t));
    chk({tag, "_ones"}, 32'(hour_ones), 32'(o));
    chk({tag, "_pm"},   32'(hour_pm),   32'(p));
  endtask

  task automatic pulse_up();
    hour_up = 1'b1; step();
    hour_up = 1'b0; step();
  endtask

  task automatic pulse_dn();
    hour_dn = 1'b1; step();
    hour_dn = 1'b0; step();
  endtask

  initial begin
    hour_rst_n    = 1'b0;
    hour_carry_in = 1'b0;
    hour_fmt24    = 1'b0;
    hour_set      = 1'b0;
    hour_up       = 1'b0;
    hour_dn       = 1'b0;

    // Reset state
    repeat (2) step();
    disp_is("rst", 0, 0, 0);
    chk("rst_day", 32'(hour_day_out), 32'd0);

    // First edge after release shows midnight in 12 h mode
    hour_rst_n = 1'b1;
    step();
    disp_is("rel12h", 1, 2, 0);

    // Long carry high period gives a single increment
    hour_fmt24 = 1'b1;
    step();
    disp_is("fmt24", 0, 0, 0);
    hour_carry_in = 1'b1;
    repeat (60) step();
    disp_is("carry_hi", 0, 0, 0);
    hour_carry_in = 1'b0;
    step();
    disp_is("carry_evt", 0, 0, 0);
    step();
    disp_is("carry_lat", 0, 1, 0);
    repeat (3) step();
    disp_is("carry_once", 0, 1, 0);

    // Set mode: down wraps 0 -> 23 without day pulse
    hour_set = 1'b1;
    pulse_dn();
    disp_is("dn_1to0", 0, 0, 0);
    pulse_dn();
    disp_is("dn_wrap", 2, 3, 1);
    chk("dn_wrap_day", 32'(hour_day_out), 32'd0);

    // Up held for 10 cycles is a single step
    hour_up = 1'b1;
    repeat (10) step();
    hour_up = 1'b0;
    step();
    disp_is("up_held", 0, 0, 0);

    // Coincident up and down edges cancel
    hour_up = 1'b1; hour_dn = 1'b1; step();
    hour_up = 1'b0; hour_dn = 1'b0; step();
    step();
    disp_is("up_dn", 0, 0, 0);

    // Carry edges ignored in set mode
    hour_carry_in = 1'b1; repeat (3) step();
    hour_carry_in = 1'b0; repeat (3) step();
    disp_is("set_carry", 0, 0, 0);

    // Carry-driven 23 -> 0 wrap with day pulse
    pulse_dn();
    disp_is("to23", 2, 3, 1);
    hour_set = 1'b0;
    hour_carry_in = 1'b1; repeat (5) step();
    hour_carry_in = 1'b0; step();
    chk("day_hi", 32'(hour_day_out), 32'd1);
    step();
    disp_is("day_wrap", 0, 0, 0);
    chk("day_lo", 32'(hour_day_out), 32'd0);

    // 12 h display at 0, 12 and 13
    hour_fmt24 = 1'b0;
    step();
    disp_is("h12_0", 1, 2, 0);
    hour_set = 1'b1;
    repeat (12) pulse_up();
    disp_is("h12_12", 1, 2, 1);
    pulse_up();
    disp_is("h12_13", 0, 1, 1);

    // Reset with count 15 and a coincident carry event
    pulse_up();
    pulse_up();
    hour_fmt24 = 1'b1;
    hour_set = 1'b0;
    hour_carry_in = 1'b1; repeat (3) step();
    disp_is("pre15", 1, 5, 1);
    hour_carry_in = 1'b0;
    hour_rst_n = 1'b0;
    step();
    disp_is("rst15", 0, 0, 0);
    chk("rst15_day", 32'(hour_day_out), 32'd0);
    hour_rst_n = 1'b1;
    repeat (3) step();
    disp_is("rst15_rel", 0, 0, 0);

    // Up held across reset release gives no increment
    hour_set = 1'b1;
    hour_up = 1'b1;
    hour_rst_n = 1'b0;
    step();
    hour_rst_n = 1'b1;
    repeat (3) step();
    hour_up = 1'b0;
    step();
    disp_is("up_rst", 0, 0, 0);

    // Random traffic against the model
    repeat (400) begin
      hour_rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) hour_carry_in = ~hour_carry_in;
      if ($urandom_range(0, 15) == 0) hour_set = ~hour_set;
      if ($urandom_range(0, 15) == 0) hour_fmt24 = ~hour_fmt24;
      hour_up = ($urandom_range(0, 2) == 0);
      hour_dn = ($urandom_range(0, 3) == 0);
      step();
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
